// File: rtl/alu_sequencer.sv
// Control stage for the 8-bit ALU: accepts one request, sequences load/exec/capture,
// and returns the ALU result and flags on a valid/ready response port.
module alu_sequencer #(
  parameter int ALU_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_use_carry,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_wa,
  output logic       alu_wb,
  output logic [6:0] alu_op,
  output logic       alu_oe,
  output logic [7:0] alu_fi,
  input  logic [7:0] alu_d,
  input  logic [7:0] alu_fo,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [7:0] rsp_flags,
  output logic       rsp_err,
  output logic       carry_q
);
  localparam int CW = $clog2(ALU_LAT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPT, RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [7:0]    a_q, b_q;
  logic          fi_q;
  logic          accept;
  logic          busy;

  assign accept = req_valid && req_ready;
  assign busy   = (state == LOAD) || (state == EXEC) || (state == CAPT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = LOAD;
      LOAD: state_nx = EXEC;
      EXEC: if (cnt == '0) state_nx = CAPT;
      CAPT: state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fi_q      <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        fi_q <= req_use_carry && (req_op == 3'd0 || req_op == 3'd1) && carry_q;
      end
      // EXEC spans ALU_LAT cycles so CAPTURE closes one edge after the ALU registers d/fo
      if (state == LOAD)
        cnt <= CW'(ALU_LAT - 1);
      else if (state == EXEC && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == CAPT) begin
        rsp_data  <= alu_d;
        rsp_flags <= alu_fo;
        carry_q   <= alu_fo[0];
        rsp_err   <= (op_q == 3'd7);
      end
    end
  end

  always_comb begin
    alu_op = '0;
    for (int k = 0; k < 7; k++)
      if (busy && op_q == 3'(k)) alu_op[k] = 1'b1;
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign alu_wa    = (state == LOAD);
  assign alu_wb    = (state == LOAD);
  assign alu_oe    = (state == EXEC) || (state == CAPT);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_fi    = {7'b0, fi_q};
endmodule
